// File: rtl/sm83_bus_tracer.sv
// -----------------------------------------------------------------------------
// sm83_bus_tracer
//
// Passive monitor for the SM83 core's external memory bus. It sits next to the
// memory model and never drives the bus. Each completed read or write strobe
// becomes one {dir, addr, data} record. Records queue in a FIFO, and a consumer
// drains them through a valid/ready port.
//
// Event detection:
//   Every edge, the bus is registered into s_bus. The previous s_bus value is
//   kept in p_bus. A strobe has completed when p_bus shows it active under
//   MREQ and s_bus shows it low. The record takes its address and data from
//   p_bus, which is the last sample taken while the strobe was still high.
//   Timing:
//     E0 = the first edge that samples the strobe low.
//     E1 = the next edge; the record is pushed here.
//   If the FIFO was empty, the record appears on OUT_* right after E1.
//
// Optional feature (macro SM83_BUS_TRACER_TIMESTAMP_EN):
//   Adds a 16-bit free-running cycle counter. Each record stores the counter
//   value reached at its push edge, and the head's timestamp is shown on
//   OUT_TS. With the macro undefined, the OUT_TS port does not exist.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   OVF_W  width of the saturating dropped-event counter
//
// Ports:
//   CLK        system clock; everything is sampled on its rising edge
//   RESET      asynchronous, active-high; clears all state
//   MREQ/RD/WR core memory request and read/write strobes (active-high)
//   A, D       core address bus and data bus (data is only tapped)
//   TRACE_EN   capture enable. When low, no pushes occur, but the FIFO
//              still drains.
//   CLEAR      synchronous flush of the FIFO, OVF_CNT and CONFLICT
//   OUT_VALID  a head record is available
//   OUT_READY  the consumer accepts the head record
//   OUT_DIR    1 = write, 0 = read
//   OUT_ADDR   captured address
//   OUT_DATA   captured data
//   OUT_TS     push-edge timestamp (only with the timestamp macro)
//   LEVEL      current FIFO occupancy
//   OVF_CNT    events dropped while the FIFO was full (saturating)
//   CONFLICT   sticky; set when a read and a write complete on the same edge
// -----------------------------------------------------------------------------
module sm83_bus_tracer #(
  parameter int DEPTH = 16,
  parameter int OVF_W = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   MREQ,
  input  logic                   RD,
  input  logic                   WR,
  input  logic [15:0]            A,
  input  logic [7:0]             D,
  input  logic                   TRACE_EN,
  input  logic                   CLEAR,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   OUT_DIR,
  output logic [15:0]            OUT_ADDR,
  output logic [7:0]             OUT_DATA,
`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
  output logic [15:0]            OUT_TS,
`endif
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic [OVF_W-1:0]       OVF_CNT,
  output logic                   CONFLICT
);

  localparam int AW = $clog2(DEPTH);

  // One bus sample as seen on a single rising edge.
  typedef struct packed {
    logic        mreq;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
  } bus_t;

  // One trace record: 25 bits, or 41 bits when it carries a timestamp.
  typedef struct packed {
    logic        dir;
    logic [15:0] addr;
    logic [7:0]  data;
`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
    logic [15:0] ts;
`endif
  } rec_t;

  bus_t  s_bus;
  bus_t  p_bus;

  logic  rd_evt;
  logic  wr_evt;
  logic  push_req;
  logic  do_push;
  logic  drop;
  logic  pop;
  logic  full;
  logic  empty;

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] level;

  rec_t  new_rec;
  rec_t  head_rec;
  rec_t  last_rec;
  rec_t  out_rec;
  rec_t  mem [DEPTH];

  logic [OVF_W-1:0] ovf_cnt;
  logic             conflict;

`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
  logic [15:0] ts_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Input stage: two-deep sample history of the bus.
  // Both registers reset to zero. A strobe that is already low when reset is
  // released therefore never looks like a falling edge. The sample history is
  // deliberately not affected by CLEAR.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would collapse s_bus/p_bus into one stage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s_bus <= '0;
      p_bus <= '0;
    end else begin
      s_bus <= {MREQ, RD, WR, A, D};
      p_bus <= s_bus;
    end
  end

  // A strobe completes when the older sample shows it active under MREQ and
  // the newer sample shows it low.
  assign rd_evt = p_bus.mreq & p_bus.rd & ~s_bus.rd;
  assign wr_evt = p_bus.mreq & p_bus.wr & ~s_bus.wr;

`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
  // Free-running edge counter. It wraps naturally and ignores CLEAR.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 16'd1;
  end
`endif

  // Build the record for the current event. When a read and a write complete
  // together, the write wins, so the direction bit is simply wr_evt.
  // NOTE: always_comb gives every output a default first; a path that leaves
  // a variable unassigned would infer a latch.
  always_comb begin
    new_rec      = '0;
    new_rec.dir  = wr_evt;
    new_rec.addr = p_bus.a;
    new_rec.data = p_bus.d;
`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
    // Store the value the counter reaches on this push edge, so a push on
    // the Nth edge after reset release is stamped N.
    new_rec.ts   = ts_cnt + 16'd1;
`endif
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // The pointers carry one extra bit: equal pointers mean empty, and a
  // difference of DEPTH means full. CLEAR overrides both push and pop.
  // ---------------------------------------------------------------------------
  assign level     = wptr - rptr;
  assign empty     = (wptr == rptr);
  assign full      = (level == (AW+1)'(DEPTH));
  assign OUT_VALID = ~empty;

  assign pop       = OUT_VALID & OUT_READY & ~CLEAR;
  assign push_req  = (rd_evt | wr_evt) & TRACE_EN & ~CLEAR;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  // NOTE: the record storage has no reset. Only the pointers decide which
  // entries are meaningful, so clearing the array would add reset fan-out
  // and gain nothing.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= new_rec;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr     <= '0;
      rptr     <= '0;
      ovf_cnt  <= '0;
      conflict <= 1'b0;
      last_rec <= '0;
    end else if (CLEAR) begin
      wptr     <= '0;
      rptr     <= '0;
      ovf_cnt  <= '0;
      conflict <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (pop) begin
        rptr     <= rptr + (AW+1)'(1);
        last_rec <= head_rec;
      end
      if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_W'(1);
      if (rd_evt && wr_evt)        conflict <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output view
  // While the FIFO holds data, OUT_* shows the head entry. When it is empty,
  // OUT_* shows the last popped record (all zero after reset). This keeps the
  // outputs defined even when the head slot has never been written.
  // ---------------------------------------------------------------------------
  assign head_rec = mem[rptr[AW-1:0]];
  assign out_rec  = OUT_VALID ? head_rec : last_rec;

  assign OUT_DIR  = out_rec.dir;
  assign OUT_ADDR = out_rec.addr;
  assign OUT_DATA = out_rec.data;
`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
  assign OUT_TS   = out_rec.ts;
`endif
  assign LEVEL    = level;
  assign OVF_CNT  = ovf_cnt;
  assign CONFLICT = conflict;

endmodule

// File: tb/tb_sm83_bus_tracer.sv
// -----------------------------------------------------------------------------
// tb_sm83_bus_tracer
//
// Self-checking bench for sm83_bus_tracer. The test runs in four parts:
//   1. a table of per-cycle vectors with their expected outputs;
//   2. hand-written overflow, full push+pop and reset mid-strobe sequences;
//   3. a randomized run compared against a transaction-level model that works
//      from a list of bus samples and a record queue;
//   4. a final summary line.
// -----------------------------------------------------------------------------
module tb_sm83_bus_tracer;

  localparam int DEPTH = 16;
  localparam int OVF_W = 8;
  localparam int NV    = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic        mreq, rd, wr;
  logic [15:0] a;
  logic [7:0]  d;
  logic        en, clr, rdy;

  logic        out_valid, out_dir, conflict;
  logic [15:0] out_addr;
  logic [7:0]  out_data;
  logic [4:0]  level;
  logic [7:0]  ovf_cnt;
`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
  logic [15:0] out_ts;
`endif

  always #5 clk = ~clk;

  sm83_bus_tracer #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .MREQ     (mreq),
    .RD       (rd),
    .WR       (wr),
    .A        (a),
    .D        (d),
    .TRACE_EN (en),
    .CLEAR    (clr),
    .OUT_VALID(out_valid),
    .OUT_READY(rdy),
    .OUT_DIR  (out_dir),
    .OUT_ADDR (out_addr),
    .OUT_DATA (out_data),
`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
    .OUT_TS   (out_ts),
`endif
    .LEVEL    (level),
    .OVF_CNT  (ovf_cnt),
    .CONFLICT (conflict)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // The model keeps a list of the bus values seen on the last two edges. A
  // record is produced when the older entry shows a strobe under MREQ and the
  // newer entry shows that strobe low. Records go into a plain queue.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        mreq;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
  } smp_t;

  typedef struct packed {
    logic        dir;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] ts;
  } mrec_t;

  smp_t        m_hist[$];
  mrec_t       mq[$];
  mrec_t       m_last;
  int          m_ovf;
  bit          m_conf;
  logic [15:0] m_cycle;

  function automatic void model_reset();
    mq.delete();
    m_hist.delete();
    m_hist.push_back('0);
    m_hist.push_back('0);
    m_last  = '0;
    m_ovf   = 0;
    m_conf  = 1'b0;
    m_cycle = '0;
  endfunction

  // Called at each rising edge, with the inputs that are present on that edge.
  function automatic void model_edge();
    smp_t  older, newer;
    bit    rd_done, wr_done;
    mrec_t r;
    older   = m_hist[0];
    newer   = m_hist[1];
    m_cycle = m_cycle + 16'd1;
    rd_done = older.mreq && older.rd && !newer.rd;
    wr_done = older.mreq && older.wr && !newer.wr;
    r.dir   = wr_done;
    r.addr  = older.a;
    r.data  = older.d;
    r.ts    = m_cycle;
    if (clr) begin
      mq.delete();
      m_ovf  = 0;
      m_conf = 1'b0;
    end else begin
      if (rd_done && wr_done) m_conf = 1'b1;
      if (rdy && mq.size() > 0) m_last = mq.pop_front();
      if ((rd_done || wr_done) && en) begin
        if (mq.size() < DEPTH) mq.push_back(r);
        else if (m_ovf < 255) m_ovf++;
      end
    end
    void'(m_hist.pop_front());
    m_hist.push_back({mreq, rd, wr, a, d});
  endfunction

  task automatic cmp_model(input string tag);
    mrec_t h;
    h = (mq.size() > 0) ? mq[0] : m_last;
    check({tag, " valid"},    32'(out_valid), 32'(mq.size() > 0));
    check({tag, " level"},    32'(level),     32'(mq.size()));
    check({tag, " ovf"},      32'(ovf_cnt),   32'(m_ovf));
    check({tag, " conflict"}, 32'(conflict),  32'(m_conf));
    check({tag, " dir"},      32'(out_dir),   32'(h.dir));
    check({tag, " addr"},     32'(out_addr),  32'(h.addr));
    check({tag, " data"},     32'(out_data),  32'(h.data));
`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
    check({tag, " ts"},       32'(out_ts),    32'(h.ts));
`endif
  endtask

  // One clock cycle: the edge happens, the model advances, and the outputs
  // are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_bus();
    mreq = 1'b0; rd = 1'b0; wr = 1'b0; a = '0; d = '0;
  endtask

  task automatic rd_pulse(input logic [15:0] addr, input logic [7:0] data);
    mreq = 1'b1; rd = 1'b1; wr = 1'b0; a = addr; d = data;
    cycle();
    idle_bus();
    cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs held across one edge, outputs expected after it.
  // strb = {MREQ, RD, WR}, ctl = {TRACE_EN, CLEAR, OUT_READY}.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0]  strb;
    logic [15:0] va;
    logic [7:0]  vd;
    logic [2:0]  ctl;
    logic        ev;
    logic        edir;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic [4:0]  el;
    logic [7:0]  eo;
    logic        ec;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic [2:0] strb, input logic [15:0] va,
                              input logic [7:0] vd, input logic [2:0] ctl,
                              input logic ev, input logic edir,
                              input logic [15:0] ea, input logic [7:0] ed,
                              input logic [4:0] el, input logic [7:0] eo,
                              input logic ec);
    vec_t v;
    v.strb = strb; v.va = va; v.vd = vd; v.ctl = ctl;
    v.ev = ev; v.edir = edir; v.ea = ea; v.ed = ed;
    v.el = el; v.eo = eo; v.ec = ec;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Single read at 0x0150: it appears two edges after RD falls.
    vecs[0]  = mk(3'b110, 16'h0150, 8'h3E, 3'b100, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[1]  = mk(3'b110, 16'h0150, 8'h3E, 3'b100, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[2]  = mk(3'b100, 16'h0150, 8'h3E, 3'b100, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[3]  = mk(3'b000, 16'h0000, 8'h00, 3'b100, 1'b1, 1'b0, 16'h0150, 8'h3E, 5'd1, 8'd0, 1'b0);
    vecs[4]  = mk(3'b000, 16'h0000, 8'h00, 3'b100, 1'b1, 1'b0, 16'h0150, 8'h3E, 5'd1, 8'd0, 1'b0);
    // Write at 0xC000. It is pushed on the same edge the read is popped.
    vecs[5]  = mk(3'b101, 16'hC000, 8'hA5, 3'b100, 1'b1, 1'b0, 16'h0150, 8'h3E, 5'd1, 8'd0, 1'b0);
    vecs[6]  = mk(3'b000, 16'h0000, 8'h00, 3'b100, 1'b1, 1'b0, 16'h0150, 8'h3E, 5'd1, 8'd0, 1'b0);
    vecs[7]  = mk(3'b000, 16'h0000, 8'h00, 3'b101, 1'b1, 1'b1, 16'hC000, 8'hA5, 5'd1, 8'd0, 1'b0);
    vecs[8]  = mk(3'b000, 16'h0000, 8'h00, 3'b101, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    // RD and WR fall together: one write record, and CONFLICT is set.
    vecs[9]  = mk(3'b111, 16'h1234, 8'h56, 3'b100, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[10] = mk(3'b100, 16'h1234, 8'h56, 3'b100, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[11] = mk(3'b000, 16'h0000, 8'h00, 3'b100, 1'b1, 1'b1, 16'h1234, 8'h56, 5'd1, 8'd0, 1'b1);
    // CLEAR empties the FIFO and zeroes OVF_CNT and CONFLICT.
    vecs[12] = mk(3'b000, 16'h0000, 8'h00, 3'b110, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    // A write pulse with TRACE_EN low leaves no record.
    vecs[13] = mk(3'b101, 16'h8000, 8'h11, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[14] = mk(3'b000, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[15] = mk(3'b000, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[16] = mk(3'b000, 16'h0000, 8'h00, 3'b100, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    // CLEAR on the push edge wins over the push.
    vecs[17] = mk(3'b110, 16'h0042, 8'h99, 3'b100, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[18] = mk(3'b000, 16'h0000, 8'h00, 3'b100, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[19] = mk(3'b000, 16'h0000, 8'h00, 3'b110, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);
    vecs[20] = mk(3'b000, 16'h0000, 8'h00, 3'b100, 1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 8'd0, 1'b0);

    // ---- reset state ----
    rst = 1'b1; idle_bus(); en = 1'b1; clr = 1'b0; rdy = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset valid",    32'(out_valid), 32'd0);
    check("reset level",    32'(level),     32'd0);
    check("reset ovf",      32'(ovf_cnt),   32'd0);
    check("reset conflict", 32'(conflict),  32'd0);
    check("reset dir",      32'(out_dir),   32'd0);
    check("reset addr",     32'(out_addr),  32'd0);
    check("reset data",     32'(out_data),  32'd0);
    rst = 1'b0;
    model_reset();

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      {mreq, rd, wr} = vecs[i].strb;
      a = vecs[i].va;
      d = vecs[i].vd;
      {en, clr, rdy} = vecs[i].ctl;
      cycle();
      check($sformatf("vec%0d valid", i),    32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d level", i),    32'(level),     32'(vecs[i].el));
      check($sformatf("vec%0d ovf", i),      32'(ovf_cnt),   32'(vecs[i].eo));
      check($sformatf("vec%0d conflict", i), 32'(conflict),  32'(vecs[i].ec));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d dir", i),  32'(out_dir),  32'(vecs[i].edir));
        check($sformatf("vec%0d addr", i), 32'(out_addr), 32'(vecs[i].ea));
        check($sformatf("vec%0d data", i), 32'(out_data), 32'(vecs[i].ed));
      end
    end

    // ---- overflow: 20 reads into a 16-entry FIFO ----
    idle_bus(); en = 1'b1; clr = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 20; i++) rd_pulse(16'h0200 + 16'(i), 8'(i));
    cycle();
    check("ovf level",     32'(level),     32'd16);
    check("ovf count",     32'(ovf_cnt),   32'd4);
    check("ovf valid",     32'(out_valid), 32'd1);
    check("ovf head addr", 32'(out_addr),  32'h0200);

    // ---- full FIFO: a push and a pop on the same edge ----
    rd_pulse(16'h0300, 8'hEE);
    rdy = 1'b1;
    cycle();
    check("full pp level",     32'(level),    32'd16);
    check("full pp ovf",       32'(ovf_cnt),  32'd4);
    check("full pp head addr", 32'(out_addr), 32'h0201);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d addr", i), 32'(out_addr),
            (i < 15) ? 32'h0201 + 32'(i) : 32'h0300);
      cycle();
    end
    check("drain end valid", 32'(out_valid), 32'd0);
    check("drain end level", 32'(level),     32'd0);

    // ---- reset mid-strobe, then the timestamp of a later read ----
    rdy = 1'b0;
    mreq = 1'b1; rd = 1'b1; a = 16'h0777; d = 8'h77;
    cycle();
    cycle();
    rst = 1'b1;
    model_reset();
    idle_bus();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("post-reset%0d level", i), 32'(level),     32'd0);
      check($sformatf("post-reset%0d valid", i), 32'(out_valid), 32'd0);
    end
    repeat (4) cycle();
    rd_pulse(16'h0ABC, 8'hC3);        // high on edge 8, low on edge 9
    cycle();                          // push on edge 10
    check("ts read level", 32'(level),    32'd1);
    check("ts read dir",   32'(out_dir),  32'd0);
    check("ts read addr",  32'(out_addr), 32'h0ABC);
    check("ts read data",  32'(out_data), 32'h00C3);
`ifdef SM83_BUS_TRACER_TIMESTAMP_EN
    check("ts read stamp", 32'(out_ts),   32'd10);
`endif

    // ---- randomized traffic compared against the model ----
    for (int i = 0; i < 3000; i++) begin
      mreq = ($urandom % 4) != 0;
      rd   = ($urandom % 2) != 0;
      wr   = ($urandom % 3) == 0;
      a    = 16'($urandom);
      d    = 8'($urandom);
      en   = ($urandom % 8) != 0;
      clr  = ($urandom % 97) == 0;
      // Alternate slow and fast consumers so the FIFO both fills and drains.
      rdy  = (((i / 400) % 2) == 0) ? (($urandom % 5) == 0) : (($urandom % 5) != 0);
      cycle();
      cmp_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
